// File: rtl/wb_slave_ram.sv
// wb_slave_ram: Wishbone classic-cycle word RAM with byte-lane writes and programmable wait states.
// Define WB_SLAVE_ERR_EN to add o_wb_err, pulsed instead of ack for out-of-range requests.
module wb_slave_ram #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
`ifdef WB_SLAVE_ERR_EN
  output logic        o_wb_ack,
  output logic        o_wb_err
`else
  output logic        o_wb_ack
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef WB_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("wb_slave_ram: WAIT_STATES must be within 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  logic [31:0]       mem_data [DEPTH];
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              hit_q, hit_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       dat_q, dat_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              req_hit;
  logic              unused_adr;

  assign req_hit    = (i_wb_adr[31:ADDR_W+2] == BASE_ADR[31:ADDR_W+2]);
  assign unused_adr = ^i_wb_adr[1:0];

  // cnt is loaded with WAIT_STATES (not WAIT_STATES-1) and WAIT is always visited,
  // so WAIT lasts WAIT_STATES+1 cycles and ack rises at capture edge + 1 + WAIT_STATES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = '0;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          idx_d   = i_wb_adr[ADDR_W+1:2];
          hit_d   = req_hit;
          we_d    = i_wb_we;
          sel_d   = i_wb_sel;
          dat_d   = i_wb_dat;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_RESP;
          ack_d   = hit_q || !ERR_EN;
          err_d   = !hit_q && ERR_EN;
          mem_we  = hit_q && we_q;
          if (hit_q && !we_q) rdat_d = mem_data[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset so contents survive i_arst_n.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel_q[b]) mem_data[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

  assign o_wb_dat = rdat_q;
  assign o_wb_ack = ack_q;
`ifdef WB_SLAVE_ERR_EN
  assign o_wb_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_wb_slave_ram.sv
// Scoreboard bench for wb_slave_ram: three instances (WAIT_STATES 1/0/3) checked against an array model.
module tb_wb_slave_ram;
  localparam int ND    = 3;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    int          d;
    int          edge_n;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc  [ND];
  logic        stb  [ND];
  logic        we   [ND];
  logic [3:0]  sel  [ND];
  logic [31:0] adr  [ND];
  logic [31:0] wdat [ND];
  logic [31:0] rdat [ND];
  logic        ack  [ND];
  logic        err  [ND];

  logic [31:0] ref_mem [ND][DEPTH];
  exp_t        sb[$];
  int          cyc_cnt = 0;
  int          checks  = 0;
  int          errors  = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 1) ? 32'h8000_0000 : 32'h0000_0000;
  endfunction

  wb_slave_ram #(.ADDR_W(AW), .WAIT_STATES(1), .BASE_ADR(32'h0000_0000)) u_dut0 (
    .i_clk(clk), .i_arst_n(rst_n), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
    .i_wb_sel(sel[0]), .i_wb_adr(adr[0]), .i_wb_dat(wdat[0]), .o_wb_dat(rdat[0]),
`ifdef WB_SLAVE_ERR_EN
    .o_wb_err(err[0]),
`endif
    .o_wb_ack(ack[0]));

  wb_slave_ram #(.ADDR_W(AW), .WAIT_STATES(0), .BASE_ADR(32'h8000_0000)) u_dut1 (
    .i_clk(clk), .i_arst_n(rst_n), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
    .i_wb_sel(sel[1]), .i_wb_adr(adr[1]), .i_wb_dat(wdat[1]), .o_wb_dat(rdat[1]),
`ifdef WB_SLAVE_ERR_EN
    .o_wb_err(err[1]),
`endif
    .o_wb_ack(ack[1]));

  wb_slave_ram #(.ADDR_W(AW), .WAIT_STATES(3), .BASE_ADR(32'h0000_0000)) u_dut2 (
    .i_clk(clk), .i_arst_n(rst_n), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]), .i_wb_we(we[2]),
    .i_wb_sel(sel[2]), .i_wb_adr(adr[2]), .i_wb_dat(wdat[2]), .o_wb_dat(rdat[2]),
`ifdef WB_SLAVE_ERR_EN
    .o_wb_err(err[2]),
`endif
    .o_wb_ack(ack[2]));

`ifndef WB_SLAVE_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
  assign err[2] = 1'b0;
`endif

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Monitor: every response pulse pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      for (int d = 0; d < ND; d++) begin
        if (ack[d] === 1'b1 || err[d] === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp dut=%0d edge=%0d ack=%b err=%b required none", d, cyc_cnt, ack[d], err[d]);
          end else begin
            e = sb.pop_front();
            if (e.d != d || e.edge_n != cyc_cnt || ack[d] !== !e.err || err[d] !== e.err) begin
              errors++;
              $display("FAIL resp dut=%0d edge=%0d ack=%b err=%b required dut=%0d edge=%0d ack=%b err=%b",
                       d, cyc_cnt, ack[d], err[d], e.d, e.edge_n, !e.err, e.err);
            end
            if (e.rd) begin
              checks++;
              if (rdat[d] !== e.data) begin
                errors++;
                $display("FAIL read_data dut=%0d got=%h required=%h", d, rdat[d], e.data);
              end
            end
          end
        end else begin
          checks++;
          if (rdat[d] !== 32'h0 || ack[d] !== 1'b0 || err[d] !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs dut=%0d dat=%h ack=%b err=%b required 0", d, rdat[d], ack[d], err[d]);
          end
        end
      end
    end
  end

  task automatic xfer(input int d, input bit w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] dt, input bit hold);
    exp_t e;
    bit   hit;
    int   idx;
    int   k;
    @(posedge clk); #1;
    hit = (((a ^ base_of(d)) >> (AW + 2)) == 0);
    idx = int'((a >> 2) & 32'(DEPTH - 1));
    e.d      = d;
    e.edge_n = cyc_cnt + 2 + ws_of(d);
    e.rd     = !w;
    e.data   = hit ? ref_mem[d][idx] : 32'h0;
`ifdef WB_SLAVE_ERR_EN
    e.err = !hit;
`else
    e.err = 1'b0;
`endif
    if (w && hit) begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[d][idx][8*b +: 8] = dt[8*b +: 8];
    end
    sb.push_back(e);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; wdat[d] = dt;
    @(posedge clk); #1;
    // request is latched now; later bus changes must not matter
    adr[d] = $urandom; wdat[d] = $urandom; sel[d] = 4'($urandom); we[d] = 1'($urandom);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack[d] === 1'b1 || err[d] === 1'b1) break;
    end
    checks++;
    if (k == 40) begin
      errors++;
      $display("FAIL timeout dut=%0d waited=%0d cycles required a response", d, k);
    end
    @(posedge clk); #1;
    if (hold) begin
      @(negedge clk);
      checks++;
      if (ack[d] !== 1'b0 || err[d] !== 1'b0) begin
        errors++;
        $display("FAIL stb_held dut=%0d ack=%b err=%b required 0", d, ack[d], err[d]);
      end
      #1;
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = '0; adr[d] = '0; wdat[d] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int d = 0; d < ND; d++) ref_mem[d][i] = $urandom;
      u_dut0.mem_data[i] <= ref_mem[0][i];
      u_dut1.mem_data[i] <= ref_mem[1][i];
      u_dut2.mem_data[i] <= ref_mem[2][i];
    end
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ack[d] !== 1'b0 || err[d] !== 1'b0 || rdat[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut=%0d ack=%b err=%b dat=%h required 0", d, ack[d], err[d], rdat[d]);
      end
    end
    @(negedge clk); #2;
    rst_n = 1'b1;

    xfer(0, 1'b1, 4'hF, 32'h0000_0500, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 1'b0, 4'hF, 32'h0000_0500, 32'h0, 1'b0);

    @(posedge clk); #1;
    u_dut0.mem_data[320] <= 32'h1234_5678;
    ref_mem[0][320] = 32'h1234_5678;
    xfer(0, 1'b1, 4'b0101, 32'h0000_0500, 32'hAABB_CCDD, 1'b0);
    xfer(0, 1'b0, 4'b0000, 32'h0000_0502, 32'h0, 1'b1);

    xfer(1, 1'b1, 4'hF, 32'h8000_0010, 32'hCAFE_F00D, 1'b1);
    xfer(1, 1'b0, 4'h3, 32'h8000_0010, 32'h0, 1'b0);
    xfer(2, 1'b1, 4'hF, 32'h0000_0020, 32'h0BAD_CAFE, 1'b1);
    xfer(2, 1'b0, 4'h1, 32'h0000_0020, 32'h0, 1'b0);
    xfer(0, 1'b1, 4'b0000, 32'h0000_0024, 32'hFFFF_FFFF, 1'b0);
    xfer(0, 1'b0, 4'hF, 32'h0000_0024, 32'h0, 1'b0);

    @(posedge clk); #1;
    adr[2] = 32'h0000_0040; wdat[2] = 32'h5555_AAAA; sel[2] = 4'hF; we[2] = 1'b1;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    repeat (8) @(posedge clk);
    xfer(2, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 1'b0);

    xfer(0, 1'b1, 4'hF, 32'h0000_1000, 32'h7777_7777, 1'b0);
    xfer(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 1'b0);
    xfer(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0, 1'b0);
    xfer(1, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b0);

    for (int i = 0; i < 8; i++) xfer(0, 1'b1, 4'hF, 32'(i * 4), 32'hA5A5_0000 + 32'(i * 32'h111), 1'b0);
    for (int i = 0; i < 8; i++) xfer(0, 1'b0, 4'hF, 32'(i * 4), 32'h0, 1'b0);

    for (int n = 0; n < 90; n++) begin
      int d;
      d = $urandom_range(ND - 1);
      a = base_of(d) | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
      if ($urandom_range(7) == 0) a = a ^ (32'h1 << $urandom_range(31, AW + 2));
      xfer(d, 1'($urandom), 4'($urandom), a, $urandom, ($urandom_range(3) == 0));
    end

    // async reset while a write waits: nothing may commit
    @(posedge clk); #1;
    adr[2] = 32'h0000_0080; wdat[2] = 32'h1357_9BDF; sel[2] = 4'hF; we[2] = 1'b1;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack[2] !== 1'b0 || rdat[2] !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_wait ack=%b dat=%h required 0", ack[2], rdat[2]);
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    #5 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    xfer(2, 1'b0, 4'hF, 32'h0000_0080, 32'h0, 1'b0);

    // async reset during the ack cycle drops ack and data at once
    @(posedge clk); #1;
    adr[1] = 32'h8000_0100; sel[1] = 4'hF; we[1] = 1'b0; wdat[1] = '0;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (ack[1] !== 1'b1 || rdat[1] !== ref_mem[1][64]) begin
      errors++;
      $display("FAIL pre_reset_ack ack=%b dat=%h required ack=1 dat=%h", ack[1], rdat[1], ref_mem[1][64]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack[1] !== 1'b0 || rdat[1] !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_resp ack=%b dat=%h required 0", ack[1], rdat[1]);
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    #5 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    xfer(1, 1'b0, 4'hF, 32'h8000_0100, 32'h0, 1'b0);

    repeat (6) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_resp outstanding=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
